mcb_port_bram: RTL and testbench

// - Responder end of the Spartan-6 MCB user port (p0 cmd/wr/rd FIFOs) that the cache refill FSM drives.
// - Backs the port with on-chip BRAM of 128-bit words.
// - Used as a drop-in for the lpddr port in simulation and in DRAM-less builds; same port names minus the c3_p0_ prefix.

---
 rtl/mcb_port_bram_if.sv | 45 ++++
 rtl/mcb_port_bram.sv | 241 ++++++++++++++++++++++++
 tb/tb_mcb_port_bram.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_port_bram_if.sv
// MCB p0 user-port bundle (cmd / wr / rd FIFO sides) between the cache refill FSM (master)
// and a memory responder such as mcb_port_bram (slave).
interface mcb_port_bram_if;
  // Handshake: cmd_en / wr_en push and rd_en pops on the rising clk edge where they are high
  // and the matching full / empty flag is low; otherwise the request is dropped (cmd_en is also
  // dropped while calib_done is low) and, on the wr / rd side, the sticky error flag latches.
  logic         calib_done;
  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_byte_addr;
  logic         cmd_empty;
  logic         cmd_full;
  logic         wr_en;
  logic [15:0]  wr_mask;
  logic [127:0] wr_data;
  logic         wr_full;
  logic         wr_empty;
  logic [6:0]   wr_count;
  logic         wr_underrun;
  logic         wr_error;
  logic         rd_en;
  logic [127:0] rd_data;
  logic         rd_full;
  logic         rd_empty;
  logic [6:0]   rd_count;
  logic         rd_overflow;
  logic         rd_error;

  modport master (
    input  calib_done, cmd_empty, cmd_full,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output wr_en, wr_mask, wr_data, rd_en
  );

  modport slave (
    output calib_done, cmd_empty, cmd_full,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  wr_en, wr_mask, wr_data, rd_en
  );
endinterface

// File: rtl/mcb_port_bram.sv
// BRAM-backed responder for the Spartan-6 MCB p0 user port (128-bit words).
// Optional MCB_PORT_CALIB_DELAY_EN holds calib_done low for CALIB_CYC cycles after reset.
module mcb_port_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         dout,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Caller never pushes when full nor pops when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign dout = mem[rptr];
endmodule

module mcb_port_bram #(
  parameter int ADDR_W    = 10,
  parameter int CMD_D     = 4,
  parameter int DATA_D    = 64,
  parameter int CALIB_CYC = 256
) (
  input  logic           clk,
  input  logic           reset,
  mcb_port_bram_if.slave p,
  output logic [2:0]     fsm_state
);
  localparam int CMD_W = 2 + 6 + ADDR_W;
  localparam int CCW   = $clog2(CMD_D) + 1;
  localparam int DCW   = $clog2(DATA_D) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;

  logic              calib;
  logic [2:0]        state;
  logic [1:0]        op;          // {refresh, read}
  logic [ADDR_W-1:0] addr;
  logic [5:0]        cnt;
  logic              rd_done;
  logic              rd_pend;
  logic              rd_pend_last;
  logic              wq_valid;
  logic [ADDR_W-1:0] wq_addr;
  logic [127:0]      wq_data;
  logic [15:0]       wq_mask;
  logic [127:0]      rdata_q;
  logic              wr_underrun_q;
  logic              wr_error_q;
  logic              rd_error_q;
  logic [127:0]      mem [2**ADDR_W];

  logic [CMD_W-1:0] cmd_head;
  logic [CCW-1:0]   cmd_cnt;
  logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [143:0]     wr_head;
  logic [DCW-1:0]   wr_cnt;
  logic             wr_full, wr_empty, wr_push, wr_pop;
  logic [127:0]     rd_head;
  logic [DCW-1:0]   rd_cnt;
  logic             rd_full, rd_empty, rd_pop;
  logic [DCW:0]     rd_occ;
  logic             rd_issue;
  logic             unused_bits;

`ifdef MCB_PORT_CALIB_DELAY_EN
  localparam int CALW = $clog2(CALIB_CYC + 1);
  logic [CALW-1:0] calib_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib     <= 1'b0;
      calib_cnt <= '0;
    end else if (!calib) begin
      if (calib_cnt == CALW'(CALIB_CYC - 1)) calib <= 1'b1;
      calib_cnt <= calib_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) calib <= 1'b0;
    else       calib <= 1'b1;
  end
`endif

  assign cmd_full  = (cmd_cnt == CCW'(CMD_D));
  assign cmd_empty = (cmd_cnt == '0);
  assign cmd_push  = p.cmd_en && !cmd_full && calib;
  assign cmd_pop   = (state == S_IDLE) && !cmd_empty;

  assign wr_full   = (wr_cnt == DCW'(DATA_D));
  assign wr_empty  = (wr_cnt == '0);
  assign wr_push   = p.wr_en && !wr_full;
  assign wr_pop    = (state == S_WRITE) && !wr_empty;

  assign rd_full   = (rd_cnt == DCW'(DATA_D));
  assign rd_empty  = (rd_cnt == '0);
  assign rd_pop    = p.rd_en && !rd_empty;

  // The word in flight through the BRAM is counted so the read FIFO can never overflow.
  assign rd_occ   = {1'b0, rd_cnt} + {{DCW{1'b0}}, rd_pend};
  assign rd_issue = (state == S_READ) && !rd_done && (rd_occ < (DCW+1)'(DATA_D));

  mcb_port_fifo #(.W(CMD_W), .D(CMD_D)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(cmd_push),
    .din({p.cmd_instr[2], p.cmd_instr[0], p.cmd_bl, p.cmd_byte_addr[ADDR_W+3:4]}),
    .pop(cmd_pop), .dout(cmd_head), .count(cmd_cnt)
  );

  mcb_port_fifo #(.W(144), .D(DATA_D)) u_wr_fifo (
    .clk(clk), .reset(reset), .push(wr_push), .din({p.wr_mask, p.wr_data}),
    .pop(wr_pop), .dout(wr_head), .count(wr_cnt)
  );

  mcb_port_fifo #(.W(128), .D(DATA_D)) u_rd_fifo (
    .clk(clk), .reset(reset), .push(rd_pend), .din(rdata_q),
    .pop(rd_pop), .dout(rd_head), .count(rd_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op           <= '0;
      addr         <= '0;
      cnt          <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      wq_valid     <= 1'b0;
      wq_addr      <= '0;
      wq_data      <= '0;
      wq_mask      <= '0;
    end else begin
      wq_valid     <= wr_pop;
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (cnt == 6'd0);
      if (wr_pop) begin
        {wq_mask, wq_data} <= wr_head;
        wq_addr            <= addr;
      end
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            {op, cnt, addr} <= cmd_head;
            state           <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_done <= 1'b0;
          if (op[1])      state <= S_IDLE;
          else if (op[0]) state <= S_READ;
          else            state <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_pop) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (cnt == 6'd0) state <= S_IDLE;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (cnt == 6'd0) rd_done <= 1'b1;
          end
          if (rd_pend_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_underrun_q <= 1'b0;
      wr_error_q    <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      if ((state == S_WRITE) && wr_empty) wr_underrun_q <= 1'b1;
      if (p.wr_en && wr_full)             wr_error_q    <= 1'b1;
      if (p.rd_en && rd_empty)            rd_error_q    <= 1'b1;
    end
  end

  // BRAM: byte-enabled write one cycle after the pop, registered read.
  always_ff @(posedge clk) begin
    if (wq_valid) begin
      for (int b = 0; b < 16; b++) begin
        if (!wq_mask[b]) mem[wq_addr][8*b +: 8] <= wq_data[8*b +: 8];
      end
    end
    if (rd_issue) rdata_q <= mem[addr];
  end

  assign p.calib_done  = calib;
  assign p.cmd_empty   = cmd_empty;
  assign p.cmd_full    = cmd_full;
  assign p.wr_full     = wr_full;
  assign p.wr_empty    = wr_empty;
  assign p.wr_count    = 7'(wr_cnt);
  assign p.wr_underrun = wr_underrun_q;
  assign p.wr_error    = wr_error_q;
  assign p.rd_data     = rd_empty ? '0 : rd_head;
  assign p.rd_full     = rd_full;
  assign p.rd_empty    = rd_empty;
  assign p.rd_count    = 7'(rd_cnt);
  assign p.rd_overflow = 1'b0;
  assign p.rd_error    = rd_error_q;
  assign fsm_state     = state;

  // Auto-precharge is meaningless for BRAM and the sub-word byte offset is ignored.
  assign unused_bits = ^{p.cmd_byte_addr[29:ADDR_W+4], p.cmd_byte_addr[3:0], p.cmd_instr[1]};
endmodule

// File: tb/tb_mcb_port_bram.sv
// Directed + randomized bench for mcb_port_bram against an array/queue memory model.
module tb_mcb_port_bram;
  localparam int ADDR_W    = 10;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int DATA_D    = 64;
  localparam int CALIB_CYC = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] fsm_state;

  mcb_port_bram_if bus ();

  mcb_port_bram #(
    .ADDR_W(ADDR_W), .CMD_D(4), .DATA_D(DATA_D), .CALIB_CYC(CALIB_CYC)
  ) dut (
    .clk(clk), .reset(reset), .p(bus), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] model_mem [DEPTH];
  logic [143:0] wq_model [$];
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] mask, input logic [127:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_mask = mask;
    bus.wr_data = data;
    wq_model.push_back({mask, data});
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] instr, input int bl, input logic [29:0] baddr);
    bus.cmd_en        = 1'b1;
    bus.cmd_instr     = instr;
    bus.cmd_bl        = 6'(bl);
    bus.cmd_byte_addr = baddr;
    tick();
    bus.cmd_en = 1'b0;
  endtask

  // Reference: burst of bl+1 words from the queued write data, byte mask 1 = keep old byte.
  task automatic model_write(input int a, input int bl);
    logic [143:0] e;
    for (int i = 0; i <= bl; i++) begin
      e = wq_model.pop_front();
      for (int b = 0; b < 16; b++) begin
        if (!e[128 + b]) model_mem[(a + i) % DEPTH][8*b +: 8] = e[8*b +: 8];
      end
    end
  endtask

  task automatic model_read(input int a, input int bl);
    for (int i = 0; i <= bl; i++) exp_q.push_back(model_mem[(a + i) % DEPTH]);
  endtask

  function automatic logic [29:0] baddr_of(input int a);
    return (30'(a) << 4) | 30'($urandom_range(0, 15));
  endfunction

  task automatic wait_wr_idle(input string tag);
    int t = 0;
    while (!(bus.cmd_empty && bus.wr_empty) && t < 500) begin
      tick();
      t++;
    end
    check(tag, {bus.cmd_empty, bus.wr_empty}, 2'b11);
    repeat (3) tick();
  endtask

  task automatic drain(input string tag, input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 3000) begin
      tick();
      t++;
      if (!bus.rd_empty) begin
        check(tag, bus.rd_data, exp_q.pop_front());
        got++;
        bus.rd_en = 1'b1;
      end else begin
        bus.rd_en = 1'b0;
      end
    end
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_count"}, 128'(got), 128'(n));
  endtask

  initial begin
    int a;
    int bl;
    int t;
    logic [127:0] w;

    bus.cmd_en = 1'b0; bus.cmd_instr = '0; bus.cmd_bl = '0; bus.cmd_byte_addr = '0;
    bus.wr_en = 1'b0; bus.wr_mask = '0; bus.wr_data = '0; bus.rd_en = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_empty", bus.cmd_empty, 1'b1);
    check("rst_wr_empty", bus.wr_empty, 1'b1);
    check("rst_rd_empty", bus.rd_empty, 1'b1);
    check("rst_full", {bus.cmd_full, bus.wr_full, bus.rd_full}, 3'b000);
    check("rst_counts", {bus.wr_count, bus.rd_count}, 14'd0);
    check("rst_sticky", {bus.wr_underrun, bus.wr_error, bus.rd_error, bus.rd_overflow}, 4'b0000);
    check("rst_calib", bus.calib_done, 1'b0);
    check("rst_rd_data", bus.rd_data, 128'd0);
    check("rst_fsm_idle", fsm_state, 3'd0);

    // A command on the first edge after reset is dropped: calib_done is still low there.
    reset = 1'b0;
    send_cmd(3'b001, 0, 30'h100);
    check("drop_precalib_cmd_empty", bus.cmd_empty, 1'b1);
`ifdef MCB_PORT_CALIB_DELAY_EN
    check("calib_still_low", bus.calib_done, 1'b0);
    repeat (CALIB_CYC) tick();
`endif
    check("calib_high", bus.calib_done, 1'b1);
    repeat (6) tick();
    check("drop_precalib_no_data", bus.rd_empty, 1'b1);

    // Write then read 16 words at byte address 0x100
    for (int i = 0; i < 16; i++) push_word(16'h0, {$urandom, $urandom, $urandom, 24'($urandom), 8'(i)});
    check("wr_count_16", bus.wr_count, 7'd16);
    send_cmd(3'b000, 15, 30'h100);
    model_write(16, 15);
    send_cmd(3'b001, 15, 30'h100);
    model_read(16, 15);
    t = 0;
    while (bus.rd_count != 7'd16 && t < 200) begin
      tick();
      t++;
    end
    repeat (5) tick();
    check("rd_count_peak_16", bus.rd_count, 7'd16);
    check("wr_empty_after_burst", bus.wr_empty, 1'b1);
    drain("wr_rd_16", 16);

    // Read latency from an idle port: rd_empty falls four edges after the cmd_en edge
    a = 16 + $urandom_range(0, 15);
    send_cmd(3'b001, 0, baddr_of(a));
    model_read(a, 0);
    tick();
    check("lat_e1_empty", bus.rd_empty, 1'b1);
    tick();
    check("lat_e2_empty", bus.rd_empty, 1'b1);
    tick();
    check("lat_e3_empty", bus.rd_empty, 1'b1);
    tick();
    check("lat_e4_ready", bus.rd_empty, 1'b0);
    drain("lat_data", 1);

    // Byte mask on word 3
    push_word(16'h0, {128{1'b1}});
    send_cmd(3'b000, 0, 30'h30);
    model_write(3, 0);
    push_word(16'hFFFE, 128'd0);
    send_cmd(3'b010, 0, 30'h30);
    model_write(3, 0);
    wait_wr_idle("mask_wr_idle");
    send_cmd(3'b001, 0, 30'h30);
    model_read(3, 0);
    drain("byte_mask", 1);

    // Underrun: 4-word burst with only 2 words queued
    a = $urandom_range(100, 900);
    for (int i = 0; i < 2; i++) push_word(16'h0, {$urandom, $urandom, $urandom, $urandom});
    send_cmd(3'b000, 3, baddr_of(a));
    repeat (20) tick();
    check("underrun_flag", bus.wr_underrun, 1'b1);
    check("underrun_stalled_cmd_taken", {bus.cmd_empty, bus.wr_empty}, 2'b11);
    for (int i = 0; i < 2; i++) push_word(16'h0, {$urandom, $urandom, $urandom, $urandom});
    model_write(a, 3);
    wait_wr_idle("underrun_done");
    send_cmd(3'b001, 3, baddr_of(a));
    model_read(a, 3);
    drain("underrun_readback", 4);

    // Randomized bursts: full write, masked overwrite, optional refresh, readback
    for (int k = 0; k < 5; k++) begin
      a  = $urandom_range(0, DEPTH - 1);
      bl = $urandom_range(0, 15);
      for (int i = 0; i <= bl; i++) push_word(16'h0, {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i <= bl; i++) push_word(16'($urandom), {$urandom, $urandom, $urandom, $urandom});
      send_cmd(3'b000, bl, baddr_of(a));
      model_write(a, bl);
      send_cmd(3'b010, bl, baddr_of(a));
      model_write(a, bl);
      if (k % 2 == 1) send_cmd(3'b100 | 3'($urandom_range(0, 3)), $urandom_range(0, 63), 30'($urandom));
      send_cmd(3'b011, bl, baddr_of(a));
      model_read(a, bl);
      drain("rand_burst", bl + 1);
    end

    // Fill memory with the word index
    for (int blk = 0; blk < DEPTH / 64; blk++) begin
      for (int i = 0; i < 64; i++) push_word(16'h0, 128'(blk * 64 + i));
      send_cmd(3'b000, 63, 30'(blk * 64) << 4);
      model_write(blk * 64, 63);
      wait_wr_idle("fill_idle");
    end

    // Backpressure and wrap: 64-word read from the last word with rd_en held low
    send_cmd(3'b001, 63, 30'(DEPTH - 1) << 4);
    model_read(DEPTH - 1, 63);
    t = 0;
    while (!bus.rd_full && t < 400) begin
      tick();
      t++;
    end
    repeat (10) tick();
    check("bp_rd_full", bus.rd_full, 1'b1);
    check("bp_rd_count", bus.rd_count, 7'd64);
    check("bp_no_overflow", bus.rd_overflow, 1'b0);
    w = 128'(DEPTH - 1);
    check("bp_head_last_word", bus.rd_data, w);
    drain("bp_wrap", 64);

    // Error flags
    check("rd_error_clear", bus.rd_error, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rd_error_set", bus.rd_error, 1'b1);
    check("rd_empty_no_pop", bus.rd_count, 7'd0);
    for (int i = 0; i < 64; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_mask = '0;
      bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    bus.wr_en = 1'b0;
    check("wr_error_before_65", bus.wr_error, 1'b0);
    check("wr_full_64", bus.wr_full, 1'b1);
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("wr_error_set", bus.wr_error, 1'b1);
    check("wr_count_64", bus.wr_count, 7'd64);

    // Reset in the middle of a write burst
    send_cmd(3'b000, 63, 30'h0);
    repeat (10) tick();
    check("midburst_draining", bus.wr_count < 7'd64, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_wr", {bus.wr_empty, bus.wr_count}, {1'b1, 7'd0});
    check("mid_rst_cmd_empty", bus.cmd_empty, 1'b1);
    check("mid_rst_sticky", {bus.wr_underrun, bus.wr_error, bus.rd_error}, 3'b000);
    check("mid_rst_calib", bus.calib_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
